// File: rtl/spi_slave_if.sv
// SPI slave front end for the single-port sync RAM: deserialises MOSI frames into {cmd, payload}
// words and serialises the RAM read byte onto MISO. Optional macro SPI_SLV_TXTIMEOUT_EN bounds RD_WAIT.
module spi_slave_if #(
    parameter int ADDR_SIZE  = 8,
    parameter int TX_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [7:0]           tx_data,
    input  logic                 tx_valid
);

    localparam int W     = ADDR_SIZE + 2;
    localparam int CNT_W = $clog2(W) + 1;
    localparam int TO_W  = (TX_TIMEOUT < 2) ? 1 : $clog2(TX_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        RD_WAIT,
        RD_SHIFT,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [W-2:0]     shift_reg, shift_next;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
    logic             rd_addr_seen, rd_seen_next;
    logic [7:0]       tx_shift, tx_shift_next;
    logic [2:0]       tx_cnt, tx_cnt_next;
    logic [TO_W-1:0]  wait_cnt, wait_next;
    logic             miso_next;
    logic [W-1:0]     rx_data_next;
    logic             rx_valid_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            rd_addr_seen <= 1'b0;
            tx_shift     <= '0;
            tx_cnt       <= '0;
            wait_cnt     <= '0;
            MISO         <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
        end else begin
            state        <= state_next;
            shift_reg    <= shift_next;
            bit_cnt      <= bit_cnt_next;
            rd_addr_seen <= rd_seen_next;
            tx_shift     <= tx_shift_next;
            tx_cnt       <= tx_cnt_next;
            wait_cnt     <= wait_next;
            MISO         <= miso_next;
            rx_data      <= rx_data_next;
            rx_valid     <= rx_valid_next;
        end
    end

    // Releasing SS_n aborts any transaction; a partial frame leaves rd_addr_seen untouched.
    always_comb begin
        state_next    = state;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt;
        rd_seen_next  = rd_addr_seen;
        tx_shift_next = tx_shift;
        tx_cnt_next   = tx_cnt;
        wait_next     = wait_cnt;
        miso_next     = 1'b0;
        rx_data_next  = rx_data;
        rx_valid_next = 1'b0;

        if (state != IDLE && SS_n) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt_next = '0;
                    if (!SS_n)
                        state_next = CHK_CMD;
                end
                CHK_CMD: begin
                    shift_next   = {{(W-2){1'b0}}, MOSI};
                    bit_cnt_next = CNT_W'(1);
                    if (!MOSI)
                        state_next = WRITE;
                    else if (rd_addr_seen)
                        state_next = READ_DATA;
                    else
                        state_next = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    shift_next   = {shift_reg[W-3:0], MOSI};
                    bit_cnt_next = bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(W-1)) begin
                        rx_data_next  = {shift_reg, MOSI};
                        rx_valid_next = 1'b1;
                        wait_next     = '0;
                        tx_cnt_next   = '0;
                        case (state)
                            READ_ADD: begin
                                rd_seen_next = 1'b1;
                                state_next   = DONE;
                            end
                            READ_DATA: begin
                                rd_seen_next = 1'b0;
                                state_next   = RD_WAIT;
                            end
                            default: state_next = DONE;
                        endcase
                    end
                end
                RD_WAIT: begin
                    if (tx_valid) begin
                        miso_next     = tx_data[7];
                        tx_shift_next = {tx_data[6:0], 1'b0};
                        tx_cnt_next   = '0;
                        state_next    = RD_SHIFT;
                    end else begin
`ifdef SPI_SLV_TXTIMEOUT_EN
                        if (wait_cnt == TO_W'(TX_TIMEOUT - 1))
                            state_next = DONE;
                        else
                            wait_next = wait_cnt + 1'b1;
`else
                        // Without the timeout the counter only saturates; the wait is unbounded.
                        if (wait_cnt != '1)
                            wait_next = wait_cnt + 1'b1;
`endif
                    end
                end
                RD_SHIFT: begin
                    if (tx_cnt == 3'd7) begin
                        state_next = DONE;
                    end else begin
                        miso_next     = tx_shift[7];
                        tx_shift_next = {tx_shift[6:0], 1'b0};
                        tx_cnt_next   = tx_cnt + 3'd1;
                    end
                end
                DONE: begin
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: table of full frames plus hand-written abort, reset and
// long-wait sequences; honours SPI_SLV_TXTIMEOUT_EN for the long-wait expectation.
module tb_spi_slave_if;

    localparam int ADDR_SIZE = 8;
    localparam int W         = ADDR_SIZE + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         SS_n;
    logic         MOSI;
    logic         MISO;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic [7:0]   tx_data;
    logic         tx_valid;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [W-1:0] frame;
        logic [7:0]   tx;
        logic [W-1:0] exp_rx;
        logic [7:0]   exp_miso;
    } vec_t;

    vec_t vecs [10];

    spi_slave_if #(.ADDR_SIZE(ADDR_SIZE), .TX_TIMEOUT(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic shift_frame(input logic [W-1:0] f, input int nbits, output int pulses);
        pulses = 0;
        for (int i = 0; i < nbits; i++) begin
            MOSI = f[W-1-i];
            tick();
            if (rx_valid) pulses++;
        end
    endtask

    task automatic collect_miso(output logic [7:0] got, output int extra);
        got   = '0;
        extra = 0;
        tick();
        got[7]   = MISO;
        extra   += int'(rx_valid);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        for (int k = 6; k >= 0; k--) begin
            tick();
            got[k] = MISO;
            extra += int'(rx_valid);
        end
    endtask

    // One full SS_n window: frame in, tx_valid two cycles after rx_valid, 8 MISO bits, release.
    task automatic applyStimulus(input vec_t v, input string tag);
        int p;
        int extra;
        int e2;
        logic [7:0] got;
        SS_n     = 1'b0;
        tx_valid = 1'b0;
        tick();
        shift_frame(v.frame, W, p);
        checkOutput({tag, " rx_valid pulse"}, 32'(rx_valid), 32'd1);
        checkOutput({tag, " rx_data"}, 32'(rx_data), 32'(v.exp_rx));
        MOSI = 1'b1;
        tick();
        extra    = int'(rx_valid);
        tx_data  = v.tx;
        tx_valid = 1'b1;
        collect_miso(got, e2);
        tick();
        checkOutput({tag, " miso tail"}, 32'(MISO), 32'd0);
        checkOutput({tag, " miso byte"}, 32'(got), 32'(v.exp_miso));
        checkOutput({tag, " rx_valid count"}, 32'(p + extra + e2), 32'd1);
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
        checkOutput({tag, " idle miso"}, 32'(MISO), 32'd0);
    endtask

    initial begin
        int p;
        int highs;
        int e2;
        logic [7:0] got;
        logic [2:0] head;

        vecs[0] = '{10'h05A, 8'hA5, 10'h05A, 8'h00};
        vecs[1] = '{10'h1C3, 8'h3C, 10'h1C3, 8'h00};
        vecs[2] = '{10'h25A, 8'hA5, 10'h25A, 8'h00};
        vecs[3] = '{10'h300, 8'hA5, 10'h300, 8'hA5};
        vecs[4] = '{10'h3FF, 8'h3C, 10'h3FF, 8'h00};
        vecs[5] = '{10'h2C7, 8'h3C, 10'h2C7, 8'h3C};
        vecs[6] = '{10'h1FF, 8'hFF, 10'h1FF, 8'h00};
        vecs[7] = '{10'h200, 8'h81, 10'h200, 8'h00};
        vecs[8] = '{10'h0AA, 8'h81, 10'h0AA, 8'h00};
        vecs[9] = '{10'h2FF, 8'h81, 10'h2FF, 8'h81};

        rst      = 1'b1;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        tick();
        tick();
        checkOutput("reset MISO", 32'(MISO), 32'd0);
        checkOutput("reset rx_data", 32'(rx_data), 32'd0);
        checkOutput("reset rx_valid", 32'(rx_valid), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++)
            applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Abort after 5 bits of what would be a READ_DATA frame; rd_addr_seen must survive.
        applyStimulus('{10'h211, 8'h11, 10'h211, 8'h00}, "abort pre");
        SS_n = 1'b0;
        tick();
        shift_frame(10'h2C0, 5, p);
        SS_n = 1'b1;
        tick();
        if (rx_valid) p++;
        checkOutput("abort no rx_valid", 32'(p), 32'd0);
        checkOutput("abort rx_data held", 32'(rx_data), 32'h211);
        checkOutput("abort miso", 32'(MISO), 32'd0);
        applyStimulus('{10'h3AB, 8'hC3, 10'h3AB, 8'hC3}, "abort post");

        // Reset in the middle of RD_SHIFT after three MISO bits.
        applyStimulus('{10'h2AA, 8'h00, 10'h2AA, 8'h00}, "rst pre");
        SS_n = 1'b0;
        tick();
        shift_frame(10'h3AA, W, p);
        checkOutput("rst frame rx_data", 32'(rx_data), 32'h3AA);
        MOSI = 1'b0;
        tick();
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick();
        head[2]  = MISO;
        tx_valid = 1'b0;
        tick();
        head[1] = MISO;
        tick();
        head[0] = MISO;
        checkOutput("rst pre-reset miso", 32'(head), 32'h5);
        rst  = 1'b1;
        SS_n = 1'b1;
        tick();
        checkOutput("rst miso", 32'(MISO), 32'd0);
        checkOutput("rst rx_data", 32'(rx_data), 32'd0);
        checkOutput("rst rx_valid", 32'(rx_valid), 32'd0);
        rst = 1'b0;
        tick();
        applyStimulus('{10'h355, 8'h5A, 10'h355, 8'h00}, "rst post");

        // Long wait in RD_WAIT with no tx_valid.
        SS_n = 1'b0;
        tick();
        shift_frame(10'h301, W, p);
        checkOutput("wait rx_data", 32'(rx_data), 32'h301);
        highs = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (MISO) highs++;
        end
        checkOutput("wait miso quiet", 32'(highs), 32'd0);
        tx_data  = 8'h96;
        tx_valid = 1'b1;
        collect_miso(got, e2);
`ifdef SPI_SLV_TXTIMEOUT_EN
        checkOutput("wait late byte", 32'(got), 32'h00);
`else
        checkOutput("wait late byte", 32'(got), 32'h96);
`endif
        SS_n = 1'b1;
        tick();
        applyStimulus('{10'h2F0, 8'hFF, 10'h2F0, 8'h00}, "after wait");
        applyStimulus('{10'h30F, 8'h5A, 10'h30F, 8'h5A}, "final read");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
